// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer: opcodes, FSM states and
// instruction field positions.
package ctrl_pkg;

  localparam logic [3:0] OP_CPYIN  = 4'h0;
  localparam logic [3:0] OP_CPYOUT = 4'h1;
  localparam logic [3:0] OP_ALU    = 4'h2;
  localparam logic [3:0] OP_LOAD   = 4'h3;
  localparam logic [3:0] OP_STORE  = 4'h4;
  localparam logic [3:0] OP_CMP    = 4'h5;
  localparam logic [3:0] OP_BRZ    = 4'h6;
  localparam logic [3:0] OP_HALT   = 4'h7;

  localparam int unsigned OPC_MSB = 8;
  localparam int unsigned OPC_LSB = 5;
  localparam int unsigned ALU_MSB = 4;
  localparam int unsigned ALU_LSB = 3;
  localparam int unsigned OFS_MSB = 4;
  localparam int unsigned OFS_LSB = 0;
  localparam int unsigned REG_MSB = 2;
  localparam int unsigned REG_LSB = 0;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StMemWait,
    StWb,
    StHalted
  } ctrl_state_e;

  // What the FSM does after the single EXEC cycle.
  typedef enum logic [1:0] {
    ClsNext,
    ClsMem,
    ClsBranch,
    ClsHalt
  } exec_cls_e;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decoder: EXEC-cycle strobes, memory request type and
// the class of state transition that follows.
module instr_decode
  import ctrl_pkg::*;
(
  input  logic [3:0] opcode_i,
  input  logic [1:0] alu_field_i,
  output logic       cpyin_o,
  output logic       cpyout_o,
  output logic       comp_o,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic [1:0] alu_op_o,
  output exec_cls_e  cls_o
);

  always_comb begin
    cpyin_o   = 1'b0;
    cpyout_o  = 1'b0;
    comp_o    = 1'b0;
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    alu_op_o  = 2'b00;
    cls_o     = ClsNext;
    unique case (opcode_i)
      OP_CPYIN:  cpyin_o = 1'b1;
      OP_CPYOUT: cpyout_o = 1'b1;
      OP_ALU:    alu_op_o = alu_field_i;
      OP_LOAD: begin
        mem_req_o = 1'b1;
        cls_o     = ClsMem;
      end
      OP_STORE: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        cls_o     = ClsMem;
      end
      OP_CMP:    comp_o = 1'b1;
      OP_BRZ:    cls_o = ClsBranch;
      OP_HALT:   cls_o = ClsHalt;
      default:   cls_o = ClsNext;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle fetch/exec control sequencer driving the accumulator register
// file strobes; owns the PC, branch resolution and halt.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INSTR_W = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_ready,
  input  logic               zero_flag,
  output logic               cpyin,
  output logic               cpyout,
  output logic               memLoad,
  output logic               comp,
  output logic [2:0]         reg_sel,
  output logic [1:0]         alu_op,
  output logic [PC_W-1:0]    pc,
  output logic               halted
);

  localparam logic [PC_W-1:0] PcOne = PC_W'(1);

  ctrl_state_e        state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;

  logic      dec_cpyin, dec_cpyout, dec_comp, dec_mem_req, dec_mem_we;
  logic [1:0] dec_alu_op;
  exec_cls_e dec_cls;
  logic [PC_W-1:0] br_ofs;

  instr_decode u_decode (
    .opcode_i    (ir_q[OPC_MSB:OPC_LSB]),
    .alu_field_i (ir_q[ALU_MSB:ALU_LSB]),
    .cpyin_o     (dec_cpyin),
    .cpyout_o    (dec_cpyout),
    .comp_o      (dec_comp),
    .mem_req_o   (dec_mem_req),
    .mem_we_o    (dec_mem_we),
    .alu_op_o    (dec_alu_op),
    .cls_o       (dec_cls)
  );

  assign br_ofs = {{(PC_W-5){ir_q[OFS_MSB]}}, ir_q[OFS_MSB:OFS_LSB]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          pc_d    = '0;
        end
      end
      StFetch: begin
        if (imem_valid) begin
          ir_d    = imem_rdata;
          state_d = StExec;
        end
      end
      StExec: begin
        unique case (dec_cls)
          ClsNext: begin
            pc_d    = pc_q + PcOne;
            state_d = StFetch;
          end
          ClsMem:  state_d = StMemWait;
          ClsBranch: begin
            pc_d    = zero_flag ? pc_q + br_ofs : pc_q + PcOne;
            state_d = StFetch;
          end
          ClsHalt: state_d = StHalted;
          default: state_d = StFetch;
        endcase
      end
      StMemWait: begin
        // Stores retire here; loads need the write-back cycle.
        if (dmem_ready) begin
          if (dec_mem_we) begin
            pc_d    = pc_q + PcOne;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end
      end
      StWb: begin
        pc_d    = pc_q + PcOne;
        state_d = StFetch;
      end
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    cpyin    = 1'b0;
    cpyout   = 1'b0;
    memLoad  = 1'b0;
    comp     = 1'b0;
    reg_sel  = 3'b000;
    alu_op   = 2'b00;
    halted   = 1'b0;
    unique case (state_q)
      StFetch: imem_req = 1'b1;
      StExec: begin
        cpyin    = dec_cpyin;
        cpyout   = dec_cpyout;
        comp     = dec_comp;
        alu_op   = dec_alu_op;
        dmem_req = dec_mem_req;
        dmem_we  = dec_mem_we;
        reg_sel  = ir_q[REG_MSB:REG_LSB];
      end
      StMemWait: begin
        dmem_req = 1'b1;
        dmem_we  = dec_mem_we;
        reg_sel  = ir_q[REG_MSB:REG_LSB];
      end
      StWb: begin
        memLoad = 1'b1;
        reg_sel = ir_q[REG_MSB:REG_LSB];
      end
      StHalted: halted = 1'b1;
      default: ;
    endcase
  end

  assign pc        = pc_q;
  assign imem_addr = pc_q;

endmodule
